ad7490_sample_store: RTL and testbench



---
 rtl/ad7490_sample_store_if.sv | 29 ++
 rtl/ad7490_sample_store.sv | 157 +++++++++++++++
 tb/tb_ad7490_sample_store.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ad7490_sample_store_if.sv
`timescale 1ns/1ps
// Bus bundle for ad7490_sample_store: AD7490 frame stream in, Avalon-MM control slave.
// master = frame engine / host side, slave = sample store.
interface ad7490_sample_store_if;
   logic [15:0] asi_frame_data;
   logic        asi_frame_valid;
   logic        asi_frame_ready;
   logic [4:0]  avs_ctrl_address;
   logic        avs_ctrl_read;
   logic        avs_ctrl_write;
   logic [31:0] avs_ctrl_writedata;
   logic [3:0]  avs_ctrl_byteenable;
   logic [31:0] avs_ctrl_readdata;
   logic        avs_ctrl_waitrequest;

   modport master (
      output asi_frame_data, asi_frame_valid,
      output avs_ctrl_address, avs_ctrl_read, avs_ctrl_write,
      output avs_ctrl_writedata, avs_ctrl_byteenable,
      input  asi_frame_ready, avs_ctrl_readdata, avs_ctrl_waitrequest
   );

   modport slave (
      input  asi_frame_data, asi_frame_valid,
      input  avs_ctrl_address, avs_ctrl_read, avs_ctrl_write,
      input  avs_ctrl_writedata, avs_ctrl_byteenable,
      output asi_frame_ready, avs_ctrl_readdata, avs_ctrl_waitrequest
   );
endinterface

// File: rtl/ad7490_sample_store.sv
`timescale 1ns/1ps
// Per-channel AD7490 sample store with fresh/overrun flags, Avalon-MM readout and IRQ.
// Build macro AD7490_AVG_EN: each slot averages 4 frames before publishing a sample.
//
// state    | meaning
// ST_IDLE  | frames accepted, CTRL write may launch a clear sweep
// ST_SWEEP | zeroing slot r_idx each cycle, frames held off
module ad7490_sample_store #(
   parameter int CH_NUM = 16,
   parameter int DATA_W = 12
) (
   input  logic                 csi_MCLK_clk,
   input  logic                 rsi_MRST_reset_n,
   ad7490_sample_store_if.slave s_if,
   output logic                 ins_irq_irq
);
   localparam int CH_W  = 4;
   localparam int SMP_W = CH_W + DATA_W;

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   state_t            r_state;
   logic [CH_W-1:0]   r_idx;
   logic [SMP_W-1:0]  r_smp [CH_NUM];
   logic [CH_NUM-1:0] r_fresh;
   logic [CH_NUM-1:0] r_ovr;
   logic [CH_NUM-1:0] r_mask;
   logic [31:0]       r_frame_cnt;
   logic [31:0]       r_readdata;
   logic              r_rd_pend;
   logic              r_irq;

   logic [CH_W-1:0]   w_ch;
   logic [DATA_W-1:0] w_din;
   logic              w_accept;
   logic              w_rd_first;
   logic              w_rd_clear;
   logic [CH_W-1:0]   w_rd_idx;
   logic              w_mask_wr;
   logic              w_ctrl_start;
   logic              w_store;
   logic [DATA_W-1:0] w_store_data;
   logic [31:0]       w_rd_data;

   assign w_ch         = s_if.asi_frame_data[15:12];
   assign w_din        = s_if.asi_frame_data[DATA_W-1:0];
   assign w_accept     = s_if.asi_frame_valid && (r_state == ST_IDLE);
   assign w_rd_first   = s_if.avs_ctrl_read && !r_rd_pend;
   assign w_rd_clear   = s_if.avs_ctrl_read && r_rd_pend && !s_if.avs_ctrl_address[4];
   assign w_rd_idx     = s_if.avs_ctrl_address[3:0];
   assign w_mask_wr    = s_if.avs_ctrl_write && (s_if.avs_ctrl_address == 5'd18);
   assign w_ctrl_start = s_if.avs_ctrl_write && (s_if.avs_ctrl_address == 5'd19) &&
                         s_if.avs_ctrl_byteenable[0] && s_if.avs_ctrl_writedata[0] &&
                         (r_state == ST_IDLE);

`ifdef AD7490_AVG_EN
   logic [13:0] r_acc [CH_NUM];
   logic [1:0]  r_cnt [CH_NUM];
   logic [13:0] w_acc_sum;

   assign w_acc_sum    = r_acc[w_ch] + 14'(w_din);
   assign w_store      = (r_cnt[w_ch] == 2'd3);
   assign w_store_data = w_acc_sum[13:2];
`else
   assign w_store      = 1'b1;
   assign w_store_data = w_din;
`endif

   assign s_if.asi_frame_ready      = (r_state == ST_IDLE);
   assign s_if.avs_ctrl_waitrequest = w_rd_first;
   assign s_if.avs_ctrl_readdata    = r_readdata;
   assign ins_irq_irq               = r_irq;

   always_comb begin
      w_rd_data = '0;
      if (!s_if.avs_ctrl_address[4]) begin
         w_rd_data = {r_fresh[w_rd_idx], r_ovr[w_rd_idx], 10'd0, r_smp[w_rd_idx][SMP_W-1:DATA_W],
                      4'd0, r_smp[w_rd_idx][DATA_W-1:0]};
      end else begin
         case (s_if.avs_ctrl_address[3:0])
            4'd0:    w_rd_data = 32'(r_fresh);
            4'd1:    w_rd_data = 32'(r_ovr);
            4'd2:    w_rd_data = 32'(r_mask);
            4'd3:    w_rd_data = 32'(r_state == ST_SWEEP);
            4'd4:    w_rd_data = r_frame_cnt;
            default: w_rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_fresh     <= '0;
         r_ovr       <= '0;
         r_mask      <= '0;
         r_frame_cnt <= '0;
         r_readdata  <= '0;
         r_rd_pend   <= 1'b0;
         r_irq       <= 1'b0;
         for (int i = 0; i < CH_NUM; i++) begin
            r_smp[i] <= '0;
`ifdef AD7490_AVG_EN
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
`endif
         end
      end else begin
         r_rd_pend <= w_rd_first;
         r_irq     <= |(r_fresh & r_mask);
         if (w_rd_first) r_readdata <= w_rd_data;
         // Clear first so a same-cycle accept on this channel overrides it.
         if (w_rd_clear) begin
            r_fresh[w_rd_idx] <= 1'b0;
            r_ovr[w_rd_idx]   <= 1'b0;
         end
         if (w_mask_wr) begin
            if (s_if.avs_ctrl_byteenable[0]) r_mask[7:0]  <= s_if.avs_ctrl_writedata[7:0];
            if (s_if.avs_ctrl_byteenable[1]) r_mask[15:8] <= s_if.avs_ctrl_writedata[15:8];
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_frame_cnt <= r_frame_cnt + 32'd1;
`ifdef AD7490_AVG_EN
                  r_acc[w_ch] <= w_store ? 14'd0 : w_acc_sum;
                  r_cnt[w_ch] <= r_cnt[w_ch] + 2'd1;
`endif
                  if (w_store) begin
                     r_smp[w_ch]   <= {w_ch, w_store_data};
                     r_fresh[w_ch] <= 1'b1;
                     if (r_fresh[w_ch]) r_ovr[w_ch] <= 1'b1;
                  end
               end
               if (w_ctrl_start) begin
                  r_state     <= ST_SWEEP;
                  r_idx       <= '0;
                  r_frame_cnt <= '0;
               end
            end
            ST_SWEEP: begin
               r_smp[r_idx]   <= '0;
               r_fresh[r_idx] <= 1'b0;
               r_ovr[r_idx]   <= 1'b0;
`ifdef AD7490_AVG_EN
               r_acc[r_idx]   <= '0;
               r_cnt[r_idx]   <= '0;
`endif
               r_idx <= r_idx + 1'b1;
               if (r_idx == CH_W'(CH_NUM - 1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ad7490_sample_store.sv
`timescale 1ns/1ps
// Directed bench for ad7490_sample_store: frame storage, read-clear, IRQ, clear sweep, reset.
module tb_ad7490_sample_store;
   logic clk;
   logic rst_n;
   logic irq;
   int   n_chk;
   int   n_pass;

   ad7490_sample_store_if bus ();

   ad7490_sample_store dut (
      .csi_MCLK_clk     (clk),
      .rsi_MRST_reset_n (rst_n),
      .s_if             (bus),
      .ins_irq_irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %08h want %08h", tag, obs, exp);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic w1, output logic w2);
      bus.avs_ctrl_address = a;
      bus.avs_ctrl_read    = 1'b1;
      #1;
      w1 = bus.avs_ctrl_waitrequest;
      tick();
      w2 = bus.avs_ctrl_waitrequest;
      d  = bus.avs_ctrl_readdata;
      tick();
      bus.avs_ctrl_read = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        w1, w2;
      rd(a, d, w1, w2);
      chk(tag, d, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.avs_ctrl_address    = a;
      bus.avs_ctrl_writedata  = d;
      bus.avs_ctrl_byteenable = be;
      bus.avs_ctrl_write      = 1'b1;
      tick();
      bus.avs_ctrl_write = 1'b0;
   endtask

   task automatic frame(input logic [15:0] d);
      bus.asi_frame_data  = d;
      bus.asi_frame_valid = 1'b1;
      tick();
      bus.asi_frame_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        w1, w2;
      int          n;

      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      bus.asi_frame_data      = '0;
      bus.asi_frame_valid     = 1'b0;
      bus.avs_ctrl_address    = '0;
      bus.avs_ctrl_read       = 1'b0;
      bus.avs_ctrl_write      = 1'b0;
      bus.avs_ctrl_writedata  = '0;
      bus.avs_ctrl_byteenable = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      chk("rst_ready", 32'(bus.asi_frame_ready), 32'd1);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_readdata", bus.avs_ctrl_readdata, 32'd0);
      chk("rst_waitreq", 32'(bus.avs_ctrl_waitrequest), 32'd0);
      rd(5'd0, d, w1, w2);
      chk("rd_wait_first", 32'(w1), 32'd1);
      chk("rd_wait_second", 32'(w2), 32'd0);
      chk("rst_sample0", d, 32'd0);
      for (int a = 1; a < 32; a++) rdchk("rst_reg", 5'(a), 32'd0);

`ifndef AD7490_AVG_EN
      frame(16'h3ABC);
      rdchk("sample3_fresh", 5'd3, 32'h80030ABC);
      rdchk("sample3_cleared", 5'd3, 32'h00030ABC);
      rdchk("count_1", 5'd20, 32'd1);

      frame(16'h5001);
      frame(16'h5002);
      rdchk("overrun_reg", 5'd17, 32'h00000020);
      rdchk("fresh_reg", 5'd16, 32'h00000020);
      rdchk("sample5_ovr", 5'd5, 32'hC0050002);
      rdchk("overrun_after_rd", 5'd17, 32'd0);
      rdchk("count_3", 5'd20, 32'd3);

      wr(5'd18, 32'hFFFF0004, 4'b1111);
      rdchk("mask_full", 5'd18, 32'h00000004);
      wr(5'd18, 32'h00001200, 4'b0010);
      rdchk("mask_lane1", 5'd18, 32'h00001204);
      wr(5'd18, 32'h00000004, 4'b0011);

      frame(16'h2123);
      chk("irq_not_yet", 32'(irq), 32'd0);
      tick(); tick();
      chk("irq_set", 32'(irq), 32'd1);
      rdchk("sample2", 5'd2, 32'h80020123);
      tick();
      chk("irq_dropped", 32'(irq), 32'd0);

      frame(16'h7111);
      tick(); tick();
      chk("irq_masked_off", 32'(irq), 32'd0);

      // Read of SAMPLE[7] whose clear edge coincides with a new ch7 frame.
      bus.avs_ctrl_address = 5'd7;
      bus.avs_ctrl_read    = 1'b1;
      tick();
      bus.asi_frame_data  = 16'h7222;
      bus.asi_frame_valid = 1'b1;
      d = bus.avs_ctrl_readdata;
      tick();
      bus.avs_ctrl_read   = 1'b0;
      bus.asi_frame_valid = 1'b0;
      chk("collide_read_old", d, 32'h80070111);
      rdchk("collide_accept_wins", 5'd7, 32'hC0070222);
      rdchk("count_6", 5'd20, 32'd6);
`else
      wr(5'd18, 32'h00000004, 4'b0011);
`endif

      frame(16'h9555);
      wr(5'd19, 32'h00000001, 4'b0001);
      chk("sweep_ready_low", 32'(bus.asi_frame_ready), 32'd0);
      rd(5'd19, d, w1, w2);
      chk("sweep_busy", d, 32'd1);
      wr(5'd19, 32'h00000001, 4'b0001);
      bus.asi_frame_data  = 16'hA777;
      bus.asi_frame_valid = 1'b1;
      n = 0;
      while (!bus.asi_frame_ready && n < 40) begin
         tick();
         n++;
      end
      bus.asi_frame_valid = 1'b0;
      chk("sweep_len", 32'(n + 3), 32'd16);
      rdchk("sweep_count", 5'd20, 32'd0);
      rdchk("sweep_s5", 5'd5, 32'd0);
      rdchk("sweep_s7", 5'd7, 32'd0);
      rdchk("sweep_s9", 5'd9, 32'd0);
      rdchk("sweep_s10", 5'd10, 32'd0);
      rdchk("sweep_fresh", 5'd16, 32'd0);
      rdchk("sweep_ovr", 5'd17, 32'd0);
      rdchk("sweep_idle", 5'd19, 32'd0);
      wr(5'd21, 32'hFFFFFFFF, 4'b1111);
      rdchk("unused_21", 5'd21, 32'd0);
      rdchk("mask_kept", 5'd18, 32'h00000004);

      wr(5'd19, 32'h00000001, 4'b0001);
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(bus.asi_frame_ready), 32'd1);
      chk("rst_mid_readdata", bus.avs_ctrl_readdata, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      rdchk("rst_mid_busy", 5'd19, 32'd0);
      rdchk("rst_mid_mask", 5'd18, 32'd0);

`ifdef AD7490_AVG_EN
      frame(16'h1004);
      frame(16'h1005);
      frame(16'h1006);
      rdchk("avg_not_fresh", 5'd16, 32'd0);
      frame(16'h1008);
      rdchk("avg_fresh", 5'd16, 32'h00000002);
      rdchk("avg_sample1", 5'd1, 32'h80010005);
      rdchk("avg_count", 5'd20, 32'd4);
`else
      frame(16'h1004);
      rdchk("direct_fresh", 5'd16, 32'h00000002);
      rdchk("direct_sample1", 5'd1, 32'h80010004);
      rdchk("direct_count", 5'd20, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
